// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters: port 0 is the execute-stage
// integer path and port 1 is the branch-compare path. Requests are arbitrated
// round-robin, and the winner is registered into a single issue stage that drives
// the ALU. The ALU result is captured into a per-port response register with a
// valid/ready handshake. An accepted request appears at the ALU one cycle after it
// is accepted, and its response is valid one cycle after that.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   reqK_valid/ready/a/b/op         request port K (K = 0, 1)
//   rspK_valid/ready/out/test       response port K
//   alu_a, alu_b, alu_op            issue-stage drive to the ALU (zero/NOP when idle)
//   alu_out, alu_test               ALU result and compare flag
//   perf_grant0/1, perf_conflict    saturating counters, present only when
//                                   ALU_ARB_PERF_EN is defined
//
// Optional feature macro: ALU_ARB_PERF_EN

module alu_share_arbiter #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_conflict,
`endif
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [WORD_WIDTH-1:0] req0_a,
    input  logic [WORD_WIDTH-1:0] req0_b,
    input  logic [4:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [WORD_WIDTH-1:0] req1_a,
    input  logic [WORD_WIDTH-1:0] req1_b,
    input  logic [4:0]            req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [WORD_WIDTH-1:0] rsp0_out,
    output logic                  rsp0_test,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [WORD_WIDTH-1:0] rsp1_out,
    output logic                  rsp1_test,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_op,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_test
);

    localparam logic [4:0] OpNop = 5'b00000;
    localparam logic [4:0] OpEql = 5'b01011;
    localparam logic [4:0] OpBne = 5'b01100;

    logic                  issValid_q;
    logic [WORD_WIDTH-1:0] issA_q;
    logic [WORD_WIDTH-1:0] issB_q;
    logic [4:0]            issOp_q;
    logic                  issId_q;
    logic                  lastGrant_q;

    logic                  rsp0Valid_q;
    logic                  rsp1Valid_q;
    logic [WORD_WIDTH-1:0] rsp0Out_q;
    logic [WORD_WIDTH-1:0] rsp1Out_q;
    logic                  rsp0Test_q;
    logic                  rsp1Test_q;

    logic                  elig0;
    logic                  elig1;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  retireTest;

    // A port is eligible only if neither its response register nor the issue stage
    // holds one of its operations. Because of this, the response register targeted
    // by a retire is always empty, so the issue stage never needs to stall.
    always_comb begin
        elig0 = req0_valid && !rsp0Valid_q && !(issValid_q && (issId_q == 1'b0));
        elig1 = req1_valid && !rsp1Valid_q && !(issValid_q && (issId_q == 1'b1));
        // On a tie, the port that did not win last time is granted.
        grant0 = elig0 && (!elig1 || (lastGrant_q == 1'b1));
        grant1 = elig1 && (!elig0 || (lastGrant_q == 1'b0));
        accept = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The compare flag is meaningful only for the two branch-compare opcodes.
    assign retireTest = alu_test && ((issOp_q == OpEql) || (issOp_q == OpBne));

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OpNop;
        if (issValid_q) begin
            alu_a  = issA_q;
            alu_b  = issB_q;
            alu_op = issOp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issValid_q  <= 1'b0;
            issA_q      <= '0;
            issB_q      <= '0;
            issOp_q     <= OpNop;
            issId_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            issValid_q <= accept;
            if (accept) begin
                issA_q      <= grant1 ? req1_a  : req0_a;
                issB_q      <= grant1 ? req1_b  : req0_b;
                issOp_q     <= grant1 ? req1_op : req0_op;
                issId_q     <= grant1;
                lastGrant_q <= grant1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            rsp0Out_q   <= '0;
            rsp1Out_q   <= '0;
            rsp0Test_q  <= 1'b0;
            rsp1Test_q  <= 1'b0;
        end else begin
            if (rsp0Valid_q && rsp0_ready) begin
                rsp0Valid_q <= 1'b0;
            end
            if (rsp1Valid_q && rsp1_ready) begin
                rsp1Valid_q <= 1'b0;
            end
            if (issValid_q) begin
                if (issId_q == 1'b0) begin
                    rsp0Valid_q <= 1'b1;
                    rsp0Out_q   <= alu_out;
                    rsp0Test_q  <= retireTest;
                end else begin
                    rsp1Valid_q <= 1'b1;
                    rsp1Out_q   <= alu_out;
                    rsp1Test_q  <= retireTest;
                end
            end
        end
    end

    assign rsp0_valid = rsp0Valid_q;
    assign rsp1_valid = rsp1Valid_q;
    assign rsp0_out   = rsp0Out_q;
    assign rsp1_out   = rsp1Out_q;
    assign rsp0_test  = rsp0Test_q;
    assign rsp1_test  = rsp1Test_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perfGrant0_q;
    logic [31:0] perfGrant1_q;
    logic [31:0] perfConflict_q;

    // The counters saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perfGrant0_q   <= '0;
            perfGrant1_q   <= '0;
            perfConflict_q <= '0;
        end else begin
            if (grant0 && (perfGrant0_q != 32'hFFFF_FFFF)) begin
                perfGrant0_q <= perfGrant0_q + 32'd1;
            end
            if (grant1 && (perfGrant1_q != 32'hFFFF_FFFF)) begin
                perfGrant1_q <= perfGrant1_q + 32'd1;
            end
            if (elig0 && elig1 && (perfConflict_q != 32'hFFFF_FFFF)) begin
                perfConflict_q <= perfConflict_q + 32'd1;
            end
        end
    end

    assign perf_grant0   = perfGrant0_q;
    assign perf_grant1   = perfGrant1_q;
    assign perf_conflict = perfConflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter. A small behavioural ALU answers the
// issue-stage drive. Inputs change 1 ns after each rising edge, and outputs are
// sampled 1 ns after that.

module tb_alu_share_arbiter;

    localparam logic [4:0] OpAdd  = 5'b00010;
    localparam logic [4:0] OpSubu = 5'b00110;
    localparam logic [4:0] OpEql  = 5'b01011;
    localparam logic [4:0] OpBne  = 5'b01100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_test, rsp1_valid, rsp1_ready, rsp1_test;
    logic [31:0] rsp0_out, rsp1_out;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_op;
    logic        alu_test;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The flag reports a != b for BNE and a == b otherwise, so a non-compare op with
    // equal operands exposes any failure to mask the flag.
    always_comb begin
        alu_out  = 32'd0;
        alu_test = (alu_op == OpBne) ? (alu_a != alu_b) : (alu_a == alu_b);
        case (alu_op)
            OpAdd:                        alu_out = alu_a + alu_b;
            OpSubu, OpEql, OpBne:         alu_out = alu_a - alu_b;
            default:                      alu_out = 32'd0;
        endcase
    end

    alu_share_arbiter #(.WORD_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef ALU_ARB_PERF_EN
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict),
`endif
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_op       (req0_op),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_op       (req1_op),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_out      (rsp0_out),
        .rsp0_test     (rsp0_test),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_out      (rsp1_out),
        .rsp1_test     (rsp1_test),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_out       (alu_out),
        .alu_test      (alu_test)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One reset edge. On return the bench is in cycle 0 with rst_n high.
    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_out", rsp0_out, 0);
        chk("rst_rsp1_test", rsp1_test, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;

        // Single op: ADD 5 + 7 on port 0.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OpAdd;
        #1;
        chk("single_ready0_c0", req0_ready, 1);
        chk("single_alu_nop_c0", alu_op, 0);
        tick(); req0_valid = 1'b0; #1;
        chk("single_alu_op_c1", alu_op, OpAdd);
        chk("single_alu_a_c1", alu_a, 5);
        chk("single_alu_b_c1", alu_b, 7);
        chk("single_rsp0_valid_c1", rsp0_valid, 0);
        tick(); #1;
        chk("single_rsp0_valid_c2", rsp0_valid, 1);
        chk("single_rsp0_out_c2", rsp0_out, 12);
        chk("single_rsp0_test_c2", rsp0_test, 0);
        chk("single_alu_nop_c2", alu_op, 0);
        tick(); #1;
        chk("single_rsp0_valid_c3", rsp0_valid, 0);
        chk("single_rsp0_hold_c3", rsp0_out, 12);

        // Tie from reset: SUBU 10-3 on port 0, EQL 4==4 on port 1.
        doReset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = OpSubu;
        req1_valid = 1'b1; req1_a = 32'd4;  req1_b = 32'd4; req1_op = OpEql;
        #1;
        chk("tie_ready0_c0", req0_ready, 1);
        chk("tie_ready1_c0", req1_ready, 0);
        tick(); req0_valid = 1'b0; #1;
        chk("tie_ready1_c1", req1_ready, 1);
        chk("tie_alu_op_c1", alu_op, OpSubu);
        tick(); req1_valid = 1'b0; #1;
        chk("tie_rsp0_valid_c2", rsp0_valid, 1);
        chk("tie_rsp0_out_c2", rsp0_out, 7);
        chk("tie_alu_op_c2", alu_op, OpEql);
        tick(); #1;
        chk("tie_rsp1_valid_c3", rsp1_valid, 1);
        chk("tie_rsp1_test_c3", rsp1_test, 1);
        chk("tie_rsp1_out_c3", rsp1_out, 0);
        chk("tie_rsp0_valid_c3", rsp0_valid, 0);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0", perf_grant0, 1);
        chk("perf_grant1", perf_grant1, 1);
        chk("perf_conflict", perf_conflict, 1);
`endif

        // The next tie goes back to port 0. Port 1 then sees backpressure.
        tick();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = OpAdd;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_op = OpBne;
        rsp1_ready = 1'b0;
        #1;
        chk("tie2_ready0", req0_ready, 1);
        chk("tie2_ready1", req1_ready, 0);
        tick(); req0_valid = 1'b0; #1;
        chk("bp_ready1_c5", req1_ready, 1);
        tick(); #1;
        chk("bp_ready1_issue_c6", req1_ready, 0);
        chk("bp_rsp0_out_c6", rsp0_out, 3);
        tick(); #1;
        chk("bp_rsp1_valid_c7", rsp1_valid, 1);
        chk("bp_rsp1_out_c7", rsp1_out, 32'hFFFF_FFFE);
        chk("bp_rsp1_test_c7", rsp1_test, 1);
        chk("bp_ready1_c7", req1_ready, 0);
        tick(); #1;
        chk("bp_rsp1_valid_c8", rsp1_valid, 1);
        chk("bp_rsp1_hold_c8", rsp1_out, 32'hFFFF_FFFE);
        chk("bp_ready1_c8", req1_ready, 0);
        rsp1_ready = 1'b1;
        #1;
        chk("bp_ready1_released_c8", req1_ready, 0);
        tick(); req1_a = 32'd9; req1_b = 32'd9; #1;
        chk("bp_rsp1_valid_c9", rsp1_valid, 0);
        chk("bp_ready1_c9", req1_ready, 1);
        tick(); req1_valid = 1'b0; #1;
        chk("bp_alu_op_c10", alu_op, OpBne);
        chk("bp_alu_a_c10", alu_a, 9);
        tick(); #1;
        chk("bp_rsp1_valid_c11", rsp1_valid, 1);
        chk("bp_rsp1_test_c11", rsp1_test, 0);
        chk("bp_rsp1_out_c11", rsp1_out, 0);

        // Interleave: both ports stream and responses are always ready. Each port
        // can accept at most once every three cycles, so accepts go p0, p1, idle.
        // Port 0 ADD c+3 (c = 3 has equal operands, so its flag must be masked).
        // Port 1 BNE c-0.
        doReset();
        for (int c = 0; c < 9; c++) begin
            req0_valid = 1'b1; req0_a = 32'(c); req0_b = 32'd3; req0_op = OpAdd;
            req1_valid = 1'b1; req1_a = 32'(c); req1_b = 32'd0; req1_op = OpBne;
            #1;
            chk($sformatf("il_ready0_c%0d", c), req0_ready, (c % 3 == 0) ? 1 : 0);
            chk($sformatf("il_ready1_c%0d", c), req1_ready, (c % 3 == 1) ? 1 : 0);
            chk($sformatf("il_alu_op_c%0d", c), alu_op,
                (c % 3 == 1) ? OpAdd : ((c % 3 == 2) ? OpBne : 5'd0));
            chk($sformatf("il_rsp0_valid_c%0d", c), rsp0_valid, (c % 3 == 2) ? 1 : 0);
            chk($sformatf("il_rsp1_valid_c%0d", c), rsp1_valid,
                ((c % 3 == 0) && (c > 0)) ? 1 : 0);
            if (c % 3 == 2) begin
                chk($sformatf("il_rsp0_out_c%0d", c), rsp0_out, 32'(c + 1));
                chk($sformatf("il_rsp0_test_c%0d", c), rsp0_test, 0);
            end
            if ((c % 3 == 0) && (c > 0)) begin
                chk($sformatf("il_rsp1_out_c%0d", c), rsp1_out, 32'(c - 2));
                chk($sformatf("il_rsp1_test_c%0d", c), rsp1_test, 1);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();

        // Reset mid-flight: the accepted ADD is discarded.
        doReset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OpAdd;
        #1;
        chk("mf_ready0_c0", req0_ready, 1);
        tick(); req0_valid = 1'b0; rst_n = 1'b0; #1;
        chk("mf_alu_op_c1", alu_op, OpAdd);
        tick(); rst_n = 1'b1; #1;
        chk("mf_rsp0_valid_c2", rsp0_valid, 0);
        chk("mf_alu_nop_c2", alu_op, 0);
        chk("mf_rsp0_out_c2", rsp0_out, 0);
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mf_rsp0_valid_c3", rsp0_valid, 0);
        chk("mf_tie_ready0", req0_ready, 1);
        chk("mf_tie_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
